// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM (Moore, synchronous reset).
// Optional macro MULTICYCLE_CTRL_BNE_EN adds bne (op 5) via BRANCH.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic [3:0] alu_ctrl_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  state_t state_q;
  state_t state_d;

  logic       is_r;
  logic       is_mem;
  logic       is_beq;
  logic       is_bne;
  logic       is_imm;
  logic       is_j;
  logic [3:0] r_ctrl;

  assign is_mem = (instr_op_i == 6'd35) ||
                  (instr_op_i == 6'd43);
  assign is_beq = (instr_op_i == 6'd4);
  assign is_imm = (instr_op_i == 6'd8) ||
                  (instr_op_i == 6'd10);
  assign is_j   = (instr_op_i == 6'd2);

`ifdef MULTICYCLE_CTRL_BNE_EN
  assign is_bne = (instr_op_i == 6'd5);
`else
  assign is_bne = 1'b0;
`endif

  // Map R-type funct to ALU op; unknown funct marks the instr illegal.
  always_comb begin
    r_ctrl = ALU_AND;
    is_r   = 1'b0;
    if (instr_op_i == 6'd0) begin
      is_r = 1'b1;
      case (funct_i)
        6'd32:   r_ctrl = ALU_ADD;
        6'd34:   r_ctrl = ALU_SUB;
        6'd36:   r_ctrl = ALU_AND;
        6'd37:   r_ctrl = ALU_OR;
        6'd39:   r_ctrl = ALU_NOR;
        6'd42:   r_ctrl = ALU_SLT;
        default: is_r   = 1'b0;
      endcase
    end
  end

  // State register; reset wins from any state.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:
        state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_r:            state_d = S_EXEC_R;
          is_mem:          state_d = S_MEM_ADDR;
          is_beq, is_bne:  state_d = S_BRANCH;
          is_imm:          state_d = S_EXEC_I;
          is_j:            state_d = S_JUMP;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        state_d = (instr_op_i == 6'd35) ? S_MEM_RD
                                        : S_MEM_WR;
      S_MEM_RD:
        state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB: state_d = S_FETCH;
      S_MEM_WR:
        state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_EXEC_R: state_d = S_R_WB;
      S_R_WB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_EXEC_I: state_d = S_I_WB;
      S_I_WB:   state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode; everything held at zero while reset is high.
  always_comb begin
    alu_ctrl_o   = ALU_AND;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'd0;
    pc_write_o   = 1'b0;
    pc_src_o     = 2'd0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    illegal_o    = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'd1;
          alu_ctrl_o  = ALU_ADD;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_b_o = 2'd3;
          alu_ctrl_o  = ALU_ADD;
          illegal_o   = ~(is_r | is_mem | is_beq |
                          is_bne | is_imm | is_j);
        end
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'd2;
          alu_ctrl_o  = ALU_ADD;
        end
        S_MEM_RD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        S_MEM_WR: begin
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a_o = 1'b1;
          alu_ctrl_o  = r_ctrl;
        end
        S_R_WB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o = 1'b1;
          alu_ctrl_o  = ALU_SUB;
          pc_src_o    = 2'd1;
          pc_write_o  = is_bne ? ~zero_i : zero_i;
        end
        S_EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'd2;
          alu_ctrl_o  = (instr_op_i == 6'd10) ? ALU_SLT
                                              : ALU_ADD;
        end
        S_I_WB:
          reg_write_o = 1'b1;
        S_JUMP: begin
          pc_src_o   = 2'd2;
          pc_write_o = 1'b1;
        end
        default:
          illegal_o = 1'b1;
      endcase
    end
  end

  assign state_o = rst_i ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces
// built from the instruction-class rules, random + directed.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       rdy;
  logic [3:0] alu_ctrl;
  logic       src_a;
  logic [1:0] src_b;
  logic       pcw;
  logic [1:0] pc_src;
  logic       irw;
  logic       mr;
  logic       mw;
  logic       iord;
  logic       rw;
  logic       rdst;
  logic       m2r;
  logic       ill;
  logic [3:0] st;

  int checks = 0;
  int failures = 0;

  multicycle_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_op_i   (op),
    .funct_i      (funct),
    .zero_i       (zero),
    .mem_ready_i  (rdy),
    .alu_ctrl_o   (alu_ctrl),
    .alu_src_a_o  (src_a),
    .alu_src_b_o  (src_b),
    .pc_write_o   (pcw),
    .pc_src_o     (pc_src),
    .ir_write_o   (irw),
    .mem_read_o   (mr),
    .mem_write_o  (mw),
    .iord_o       (iord),
    .reg_write_o  (rw),
    .reg_dst_o    (rdst),
    .mem_to_reg_o (m2r),
    .illegal_o    (ill),
    .state_o      (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic        rdy;
    logic [17:0] o;
  } step_t;

  step_t tr[$];

  logic [17:0] obs;
  assign obs = {alu_ctrl, src_a, src_b, pcw, pc_src,
                irw, mr, mw, iord, rw, rdst, m2r, ill};

  function automatic logic [17:0] ob(
    int ctrl, int a, int b, int pw, int ps,
    int ir, int rd, int wr, int io,
    int rg, int dst, int mtr, int il);
    return {4'(ctrl), 1'(a), 2'(b), 1'(pw), 2'(ps),
            1'(ir), 1'(rd), 1'(wr), 1'(io),
            1'(rg), 1'(dst), 1'(mtr), 1'(il)};
  endfunction

  task automatic check(string tag, int act, int exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s t=%0t got=%0h exp=%0h",
             tag, $time, act, exp);
    end
  endtask

  task automatic push(int s, int r, logic [17:0] o);
    step_t e;
    e.st  = 4'(s);
    e.rdy = 1'(r);
    e.o   = o;
    tr.push_back(e);
  endtask

  function automatic int r_alu(int f);
    case (f)
      32: return 2;
      34: return 6;
      36: return 0;
      37: return 1;
      39: return 12;
      default: return 7;
    endcase
  endfunction

  // Expected trace of one instruction, fetch wait fw, mem wait mwt.
  task automatic build(int o, int f, int z, int fw, int mwt);
    bit r_ok;
    bit bne;
    bit legal;
    tr.delete();
    r_ok = (o == 0) && (f inside {32, 34, 36, 37, 39, 42});
`ifdef MULTICYCLE_CTRL_BNE_EN
    bne = (o == 5);
`else
    bne = 1'b0;
`endif
    legal = r_ok || bne ||
            (o inside {35, 43, 4, 8, 10, 2});
    for (int i = 0; i <= fw; i++) begin
      int r;
      r = (i == fw) ? 1 : 0;
      push(0, r, ob(2, 0, 1, r, 0, r, 1, 0, 0, 0, 0, 0, 0));
    end
    push(0 + 1, 0,
         ob(2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, legal ? 0 : 1));
    if (r_ok) begin
      push(6, 0, ob(r_alu(f), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      push(7, 0, ob(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    end else if (o == 35 || o == 43) begin
      push(2, 0, ob(2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i <= mwt; i++) begin
        int r;
        r = (i == mwt) ? 1 : 0;
        if (o == 35)
          push(3, r, ob(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        else
          push(5, r, ob(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      end
      if (o == 35)
        push(4, 0, ob(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    end else if (o == 4 || bne) begin
      push(8, 0, ob(6, 1, 0, bne ? !z : z, 1,
                    0, 0, 0, 0, 0, 0, 0, 0));
    end else if (o == 8 || o == 10) begin
      push(9, 0, ob(o == 10 ? 7 : 2, 1, 2, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0));
      push(10, 0, ob(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    end else if (o == 2) begin
      push(11, 0, ob(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  // Build and play one instruction; limit truncates the trace.
  task automatic run(int o, int f, int z, int fw, int mwt,
                     int limit = 1000);
    build(o, f, z, fw, mwt);
    for (int k = 0; k < tr.size() && k < limit; k++) begin
      @(negedge clk);
      if (k == 0) begin
        op    = 6'(o);
        funct = 6'(f);
        zero  = 1'(z);
      end
      rdy = tr[k].rdy;
      #1;
      check("state", int'(st), int'(tr[k].st));
      check("outs", int'(obs), int'(tr[k].o));
    end
  endtask

  initial begin
    rst   = 1'b1;
    op    = 6'd0;
    funct = 6'd0;
    zero  = 1'b0;
    rdy   = 1'b0;
    #1;
    check("rst_state", int'(st), 0);
    check("rst_outs", int'(obs), 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_state", int'(st), 0);

    // sub, zero-wait
    run(0, 34, 0, 0, 0);
    // lw with three wait cycles
    run(35, 0, 0, 0, 3);
    // beq taken / not taken
    run(4, 0, 1, 0, 0);
    run(4, 0, 0, 1, 0);
    // illegal opcode
    run(63, 0, 0, 0, 0);
    // op 5 (bne when enabled, illegal otherwise)
    run(5, 0, 0, 0, 0);
    run(8, 0, 0, 2, 0);
    run(10, 0, 0, 0, 0);
    run(2, 0, 0, 0, 0);
    run(43, 0, 0, 0, 1);

    // reset during an sw memory wait
    run(43, 0, 0, 0, 10, 6);
    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b0;
    #1;
    check("midwait_rst_state", int'(st), 0);
    check("midwait_rst_outs", int'(obs), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_rst_state", int'(st), 0);
    check("after_rst_outs", int'(obs),
          int'(ob(2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)));
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    op  = 6'd63;
    #1;
    check("resync_decode", int'(st), 1);

    // random instruction mix
    for (int n = 0; n < 60; n++) begin
      int kind;
      int o;
      int f;
      kind = $urandom_range(0, 9);
      f = 0;
      case (kind)
        0: begin
          int fs[6];
          fs = '{32, 34, 36, 37, 39, 42};
          o = 0;
          f = fs[$urandom_range(0, 5)];
        end
        1: o = 35;
        2: o = 43;
        3: o = 4;
        4: o = 8;
        5: o = 10;
        6: o = 2;
        7: begin
          o = 0;
          f = $urandom_range(0, 63);
        end
        8: o = $urandom_range(0, 63);
        default: o = 5;
      endcase
      run(o, f, $urandom_range(0, 1),
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have ports:
  - clk_i  input  1  clock; all state updates on rising edge
  - rst_i  input  1  reset; synchronous, active-high
  - instr_op_i  input  6  opcode field of the instruction register
  - funct_i  input  6  funct field of the instruction register
  - zero_i  input  1  ALU zero flag
  - mem_ready_i  input  1  memory access complete this cycle
  - alu_ctrl_o  output  4  ALU operation: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR
  - alu_src_a_o  output  1  0 = PC, 1 = register A
  - alu_src_b_o  output  2  0 = register B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm<<2
  - pc_write_o  output  1  PC load enable
  - pc_src_o  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target
  - ir_write_o, mem_read_o, mem_write_o, iord_o, reg_write_o, reg_dst_o, mem_to_reg_o  output  1 each  datapath enables/selects
  - illegal_o  output  1  one-cycle pulse on an unsupported instruction
  - state_o  output  4  current state encoding, for debug

Function
REQ-003 SHALL be a Moore FSM; outputs decode from the state register, except where gated by mem_ready_i or zero_i; all unlisted outputs SHALL be 0.
REQ-004 FETCH(0): mem_read=1, iord=0, A=0, B=1, ctrl=ADD; ir_write and pc_write = mem_ready_i; stay in FETCH until mem_ready_i, then go to DECODE.
REQ-005 DECODE(1): A=0, B=3, ctrl=ADD. Next state by opcode:
  - op 0 with funct 32/34/36/37/39/42 -> EXEC_R
  - op 35 or 43 -> MEM_ADDR
  - op 4 -> BRANCH
  - op 8 or 10 -> EXEC_I
  - op 2 -> JUMP
  - any other opcode/funct -> FETCH, with illegal_o=1 for that cycle.
REQ-006 MEM_ADDR(2): A=1, B=2, ctrl=ADD; op 35 -> MEM_RD, op 43 -> MEM_WR.
REQ-007 MEM_RD(3): mem_read=1, iord=1; hold until mem_ready_i, then go to MEM_WB(4).
REQ-008 MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
REQ-009 MEM_WR(5): mem_write=1, iord=1; hold until mem_ready_i, then go to FETCH.
REQ-010 EXEC_R(6): A=1, B=0, ctrl from funct: 32 ADD, 34 SUB, 36 AND, 37 OR, 39 NOR, 42 SLT; -> R_WB(7).
REQ-011 R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
REQ-012 BRANCH(8): A=1, B=0, ctrl=SUB, pc_src=1, pc_write=zero_i; -> FETCH.
REQ-013 EXEC_I(9): A=1, B=2; ctrl=ADD for op 8, SLT for op 10; -> I_WB(10).
REQ-014 I_WB(10): reg_write=1, reg_dst=0, mem_to_reg=0; -> FETCH.
REQ-015 JUMP(11): pc_src=2, pc_write=1; -> FETCH.
REQ-016 Unused encodings 12-15 SHALL go to FETCH on the next edge, with all enables 0 and illegal_o=1.
REQ-017 mem_read_o/mem_write_o SHALL stay asserted with constant iord_o for as long as a memory wait lasts, including an indefinite wait.
REQ-018 Instruction latency in cycles, with zero-wait memory: R/I-type 4, lw 5, sw 4, beq 3, j 3.

Reset
REQ-019 When rst_i=1 at a rising edge, state SHALL become FETCH, regardless of the current state.
REQ-020 While rst_i=1, pc_write, ir_write, mem_read, mem_write, reg_write and illegal_o SHALL be forced to 0; all other outputs SHALL be 0 except state_o=0.
REQ-021 Reset mid-wait (MEM_RD or MEM_WR) SHALL abandon the access with no write enable pulsed.

Configuration
REQ-022 Macro MULTICYCLE_CTRL_BNE_EN: when defined, op 5 SHALL decode to BRANCH with pc_write=~zero_i; when undefined, op 5 SHALL be illegal per REQ-005.

Verification
REQ-023 Reset, then mem_ready_i=1 and op 0/funct 34 -> states 0,1,6,7,0; alu_ctrl=6 in EXEC_R; reg_write=1 and reg_dst=1 only in R_WB.
REQ-024 lw (op 35) with mem_ready_i low for 3 cycles in MEM_RD -> mem_read=1 and iord=1 held for 4 cycles; one reg_write pulse with mem_to_reg=1.
REQ-025 beq (op 4) with zero_i=1 -> pc_write=1 and pc_src=1 in BRANCH; repeat with zero_i=0 -> pc_write=0.
REQ-026 op 63 -> illegal_o high exactly one cycle in DECODE, then FETCH with no write enables.
REQ-027 rst_i asserted during a MEM_WR wait -> FETCH on the next edge; mem_write=0 from the reset cycle onward.
REQ-028 op 5, zero_i=0 -> pc_write=1 with MULTICYCLE_CTRL_BNE_EN defined; illegal_o pulse without it.
